// File: rtl/tqvp_uart_fifo_if.sv
// CPU-side register bus for the TinyQV UART peripheral.
//
// Handshake: data_write and data_read are single-cycle strobes sampled on the
// rising clock edge with address (and data_in for writes) valid in the same
// cycle. There is no ready/backpressure; the peripheral accepts every strobe.
// data_out is combinational and always reflects the register at address.
interface tqvp_uart_fifo_if;
   logic [3:0] address;
   logic       data_write;
   logic       data_read;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (
      output address, data_write, data_read, data_in,
      input  data_out
   );

   modport slave (
      input  address, data_write, data_read, data_in,
      output data_out
   );
endinterface

// File: rtl/tqvp_uart_fifo.sv
// TinyQV UART peripheral: full-duplex 8N1 UART, programmable baud divisor,
// RX/TX byte FIFOs, sticky error flags, internal loopback and FIFO flush.

// Circular byte FIFO; flush beats push/pop, push while full is accepted only
// when a pop happens in the same cycle.
module tqvp_uart_fifo_buf #(
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full
);
   localparam int DEPTH = 1 << AW;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // Pointer/count update; pointers wrap naturally at AW bits
   always_comb begin
      do_pop   = pop && !empty && !flush;
      do_push  = push && (!full || do_pop) && !flush;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end
endmodule

module tqvp_uart_fifo #(
   parameter int FIFO_AW   = 3,
   parameter int DIV_W     = 16,
   parameter int DIV_RESET = 556
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          ui_in,
   output logic [7:0]          uo_out,
   tqvp_uart_fifo_if.slave     bus,
   output logic [1:0]          dbg_tx_state,
   output logic [1:0]          dbg_rx_state
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   // Control / status registers
   logic [DIV_W-1:0] div_q, div_d;
   logic tx_en_q, tx_en_d, rx_en_q, rx_en_d, loop_q, loop_d;
   logic clr_q, clr_d, flush_q, flush_d;
   logic rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d, tx_ovf_q, tx_ovf_d;

   // TX path
   uart_state_e      tx_state_q, tx_state_d;
   logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             tx_line_q, tx_line_d;
   logic             tx_pop, tx_start_ok;

   // RX path
   logic             rx_sync1_q, rx_sync2_q, rx_prev_q;
   uart_state_e      rx_state_q, rx_state_d;
   logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_push, rx_ovr_evt, frame_evt, rx_fall, rx_line;

   // FIFO wires
   logic [7:0]       tx_head, rx_head;
   logic [FIFO_AW:0] tx_count, rx_count;
   logic             tx_empty, tx_full, rx_empty, rx_full;

   // Bus decode
   logic             wr_data, rd_data, wr_ctrl, tx_ovf_evt;
   logic [DIV_W-1:0] eff_div, half_div;
   logic [15:0]      div_wide, div_wr;
   logic             unused_ok;

   assign unused_ok = &{1'b0, ui_in[6:0]};

   assign wr_data    = bus.data_write && (bus.address == 4'd0);
   assign wr_ctrl    = bus.data_write && (bus.address == 4'd4);
   assign rd_data    = bus.data_read  && (bus.address == 4'd0);
   assign tx_ovf_evt = wr_data && tx_full && !tx_pop && !flush_q;

   // Divisors below 4 would leave too few cycles per bit for mid-bit sampling
   assign eff_div  = (div_q < DIV_W'(4)) ? DIV_W'(4) : div_q;
   assign half_div = eff_div >> 1;
   assign div_wide = 16'(div_q);

   assign rx_line  = rx_sync2_q;
   assign rx_fall  = rx_prev_q && !rx_line;

   assign uo_out       = {7'b0, tx_line_q};
   assign dbg_tx_state = tx_state_q;
   assign dbg_rx_state = rx_state_q;

   tqvp_uart_fifo_buf #(.AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .rst(rst), .flush(flush_q), .push(wr_data), .pop(tx_pop),
      .wdata(bus.data_in), .rdata(tx_head), .count(tx_count),
      .empty(tx_empty), .full(tx_full)
   );

   tqvp_uart_fifo_buf #(.AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .rst(rst), .flush(flush_q), .push(rx_push), .pop(rd_data),
      .wdata(rx_shift_d), .rdata(rx_head), .count(rx_count),
      .empty(rx_empty), .full(rx_full)
   );

   // Register writes and sticky flags; a same-cycle error event beats clr_err
   always_comb begin
      div_wr   = div_wide;
      if (bus.data_write && bus.address == 4'd2) div_wr[7:0]  = bus.data_in;
      if (bus.data_write && bus.address == 4'd3) div_wr[15:8] = bus.data_in;
      div_d    = DIV_W'(div_wr);
      tx_en_d  = wr_ctrl ? bus.data_in[0] : tx_en_q;
      rx_en_d  = wr_ctrl ? bus.data_in[1] : rx_en_q;
      loop_d   = wr_ctrl ? bus.data_in[2] : loop_q;
      clr_d    = wr_ctrl && bus.data_in[3];
      flush_d  = wr_ctrl && bus.data_in[4];
      rx_ovr_d    = (clr_q ? 1'b0 : rx_ovr_q)    | rx_ovr_evt;
      frame_err_d = (clr_q ? 1'b0 : frame_err_q) | frame_evt;
      tx_ovf_d    = (clr_q ? 1'b0 : tx_ovf_q)    | tx_ovf_evt;
   end

   // Combinational read mux
   always_comb begin
      bus.data_out = 8'h00;
      case (bus.address)
         4'd0: bus.data_out = rx_empty ? 8'h00 : rx_head;
         4'd1: bus.data_out = {tx_ovf_q, frame_err_q, rx_ovr_q,
                               (tx_state_q != S_IDLE), tx_empty, tx_full,
                               rx_full, !rx_empty};
         4'd2: bus.data_out = div_wide[7:0];
         4'd3: bus.data_out = div_wide[15:8];
         4'd4: bus.data_out = {3'b000, flush_q, clr_q, loop_q, rx_en_q, tx_en_q};
         4'd5: bus.data_out = 8'(rx_count);
         4'd6: bus.data_out = 8'(tx_count);
         default: bus.data_out = 8'h00;
      endcase
   end

   // TX next-state: each bit counter is loaded from the divisor at the bit
   // boundary, so divisor writes never truncate the bit in flight
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      tx_line_d   = tx_line_q;
      tx_pop      = 1'b0;
      tx_start_ok = tx_en_q && !tx_empty && !flush_q;
      case (tx_state_q)
         S_IDLE: begin
            tx_line_d = 1'b1;
            if (tx_start_ok) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_line_d  = 1'b0;
               tx_cnt_d   = eff_div - DIV_W'(1);
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = S_DATA;
               tx_line_d  = tx_shift_q[0];
               tx_bit_d   = 3'd0;
               tx_cnt_d   = eff_div - DIV_W'(1);
            end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
         end
         S_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = eff_div - DIV_W'(1);
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = S_STOP;
                  tx_line_d  = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = tx_shift_q >> 1;
                  tx_line_d  = tx_shift_q[1];
               end
            end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
         end
         S_STOP: begin
            if (tx_cnt_q == '0) begin
               // Back-to-back frames: next start bit follows the stop bit directly
               if (tx_start_ok) begin
                  tx_pop     = 1'b1;
                  tx_shift_d = tx_head;
                  tx_line_d  = 1'b0;
                  tx_cnt_d   = eff_div - DIV_W'(1);
                  tx_state_d = S_START;
               end else tx_state_d = S_IDLE;
            end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   // RX next-state: sample mid-bit; after a framing error the line is still
   // low, so IDLE naturally waits for it to go high before the next falling edge
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push    = 1'b0;
      rx_ovr_evt = 1'b0;
      frame_evt  = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (rx_en_q && rx_fall) begin
               rx_state_d = S_START;
               rx_cnt_d   = half_div - DIV_W'(1);
            end
         end
         S_START: begin
            if (rx_cnt_q == '0) begin
               if (rx_line) rx_state_d = S_IDLE;
               else begin
                  rx_state_d = S_DATA;
                  rx_bit_d   = 3'd0;
                  rx_cnt_d   = eff_div - DIV_W'(1);
               end
            end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
         end
         S_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {rx_line, rx_shift_q[7:1]};
               rx_cnt_d   = eff_div - DIV_W'(1);
               if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
               else rx_bit_d = rx_bit_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
         end
         S_STOP: begin
            if (rx_cnt_q == '0) begin
               rx_state_d = S_IDLE;
               if (!rx_line) frame_evt = 1'b1;
               else if (rx_full && !rd_data && !flush_q) rx_ovr_evt = 1'b1;
               else rx_push = 1'b1;
            end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // All state registers; reset puts the line idle-high and both FSMs in IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q       <= DIV_W'(DIV_RESET);
         tx_en_q     <= 1'b1;
         rx_en_q     <= 1'b1;
         loop_q      <= 1'b0;
         clr_q       <= 1'b0;
         flush_q     <= 1'b0;
         rx_ovr_q    <= 1'b0;
         frame_err_q <= 1'b0;
         tx_ovf_q    <= 1'b0;
         tx_state_q  <= S_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= 3'd0;
         tx_shift_q  <= 8'h00;
         tx_line_q   <= 1'b1;
         rx_sync1_q  <= 1'b1;
         rx_sync2_q  <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= S_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= 3'd0;
         rx_shift_q  <= 8'h00;
      end else begin
         div_q       <= div_d;
         tx_en_q     <= tx_en_d;
         rx_en_q     <= rx_en_d;
         loop_q      <= loop_d;
         clr_q       <= clr_d;
         flush_q     <= flush_d;
         rx_ovr_q    <= rx_ovr_d;
         frame_err_q <= frame_err_d;
         tx_ovf_q    <= tx_ovf_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         tx_line_q   <= tx_line_d;
         rx_sync1_q  <= loop_q ? tx_line_q : ui_in[7];
         rx_sync2_q  <= rx_sync1_q;
         rx_prev_q   <= rx_sync2_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
      end
   end
endmodule

// File: tb/tb_tqvp_uart_fifo.sv
// Self-checking bench for tqvp_uart_fifo: a register-access vector table
// followed by hand-written multi-cycle UART sequences.
module tb_tqvp_uart_fifo;
   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tqvp_uart_fifo_if bus ();
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [1:0] dbg_tx_state, dbg_rx_state;

   tqvp_uart_fifo dut (
      .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .bus(bus),
      .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
   );

   typedef struct packed {
      logic [3:0] addr;
      logic       wr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs [18];
   logic [7:0] exp_q [$];
   int         n_pass  = 0;
   int         n_total = 0;

   // ---------------- scoreboard compare ----------------
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.address = 4'd0; bus.data_write = 1'b0; bus.data_read = 1'b0; bus.data_in = 8'h00;
      ui_in = 8'hFF;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // Ends on the negedge after the write edge
   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.address = a; bus.data_in = d; bus.data_write = 1'b1;
      @(negedge clk);
      bus.data_write = 1'b0;
   endtask

   // Non-destructive read, consumes no clock edge
   task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
      bus.address = a;
      #1 d = bus.data_out;
   endtask

   // Read with data_read strobe (pops RX when a == 0)
   task automatic bus_pop(input logic [3:0] a, output logic [7:0] d);
      bus.address = a; bus.data_read = 1'b1;
      #1 d = bus.data_out;
      @(negedge clk);
      bus.data_read = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [3:0] a, input logic [7:0] exp);
      logic [7:0] d;
      bus_read(a, d);
      check(name, d, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the first negedge that sees the TX line low (0.5 cycle into the start bit)
   task automatic wait_tx_fall();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (uo_out[0] == 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      check("tx_start_seen", {7'b0, seen}, 8'h01);
   endtask

   // One 8N1 frame on ui_in[7] at 8 cycles per bit, then a short idle gap
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      ui_in[7] = 1'b0; wait_cyc(8);
      for (int i = 0; i < 8; i++) begin
         ui_in[7] = b[i]; wait_cyc(8);
      end
      ui_in[7] = stop_bit; wait_cyc(8);
      ui_in[7] = 1'b1; wait_cyc(4);
   endtask

   task automatic set_div8();
      bus_write(4'd2, 8'h08);
      bus_write(4'd3, 8'h00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [7:0] d;
      logic [9:0] frame;
      int         n;

      vecs[0]  = '{4'd1, 1'b0, 8'h00, 8'h08};  // STATUS after reset
      vecs[1]  = '{4'd4, 1'b0, 8'h00, 8'h03};  // CTRL after reset
      vecs[2]  = '{4'd2, 1'b0, 8'h00, 8'h2C};  // DIV_LO = 556 & 0xFF
      vecs[3]  = '{4'd3, 1'b0, 8'h00, 8'h02};  // DIV_HI
      vecs[4]  = '{4'd5, 1'b0, 8'h00, 8'h00};  // RX_COUNT
      vecs[5]  = '{4'd6, 1'b0, 8'h00, 8'h00};  // TX_COUNT
      vecs[6]  = '{4'd0, 1'b0, 8'h00, 8'h00};  // DATA, RX empty
      vecs[7]  = '{4'd7, 1'b0, 8'h00, 8'h00};  // unmapped
      vecs[8]  = '{4'd9, 1'b1, 8'hFF, 8'h00};  // write to unmapped
      vecs[9]  = '{4'd9, 1'b0, 8'h00, 8'h00};
      vecs[10] = '{4'd2, 1'b1, 8'h08, 8'h00};
      vecs[11] = '{4'd3, 1'b1, 8'h00, 8'h00};
      vecs[12] = '{4'd2, 1'b0, 8'h00, 8'h08};
      vecs[13] = '{4'd3, 1'b0, 8'h00, 8'h00};
      vecs[14] = '{4'd4, 1'b1, 8'h07, 8'h00};
      vecs[15] = '{4'd4, 1'b0, 8'h00, 8'h07};
      vecs[16] = '{4'd4, 1'b1, 8'h03, 8'h00};
      vecs[17] = '{4'd4, 1'b0, 8'h00, 8'h03};

      do_reset();
      check("uo_out_rst", uo_out, 8'h01);
      check("dbg_states_rst", {4'b0, dbg_tx_state, dbg_rx_state}, 8'h00);
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
         else rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // ---- TX frame of 0xA5 at DIV=8 ----
      bus_write(4'd0, 8'hA5);
      wait_tx_fall();
      frame = {1'b1, 8'hA5, 1'b0};
      wait_cyc(3);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("tx_a5_bit%0d", i), {7'b0, uo_out[0]}, {7'b0, frame[i]});
         if (i < 9) wait_cyc(8);
      end
      wait_cyc(4);
      rd_check("tx_busy_at_79", 4'd1, 8'h18);
      wait_cyc(1);
      rd_check("tx_idle_at_80", 4'd1, 8'h08);

      // ---- loopback, back-to-back frames ----
      do_reset();
      set_div8();
      bus_write(4'd4, 8'h06);
      bus_write(4'd0, 8'h3C); exp_q.push_back(8'h3C);
      bus_write(4'd0, 8'hC3); exp_q.push_back(8'hC3);
      bus_write(4'd4, 8'h07);
      wait_tx_fall();
      wait_cyc(79);
      check("lb_stop1", uo_out, 8'h01);
      wait_cyc(1);
      check("lb_start2_no_gap", uo_out, 8'h00);
      wait_cyc(79);
      rd_check("lb_status_159", 4'd1, 8'h19);
      wait_cyc(1);
      rd_check("lb_status_160", 4'd1, 8'h09);
      wait_cyc(20);
      rd_check("lb_rx_count", 4'd5, 8'h02);
      while (exp_q.size() > 0) begin
         bus_pop(4'd0, d);
         check("lb_rx_data", d, exp_q.pop_front());
      end
      rd_check("lb_status_end", 4'd1, 8'h08);
      rd_check("lb_rx_count_end", 4'd5, 8'h00);

      // ---- RX overrun with 9 frames ----
      do_reset();
      set_div8();
      for (int k = 0; k < 9; k++) begin
         send_frame(8'(8'h11 * (k + 1)), 1'b1);
         if (k < 8) exp_q.push_back(8'(8'h11 * (k + 1)));
      end
      wait_cyc(4);
      rd_check("ovr_rx_count", 4'd5, 8'h08);
      rd_check("ovr_status", 4'd1, 8'h2B);
      rd_check("ovr_head", 4'd0, 8'h11);
      bus_write(4'd4, 8'h0B);
      wait_cyc(2);
      rd_check("ovr_cleared", 4'd1, 8'h0B);
      rd_check("ctrl_selfclear", 4'd4, 8'h03);
      while (exp_q.size() > 0) begin
         bus_pop(4'd0, d);
         check("ovr_rx_data", d, exp_q.pop_front());
      end
      rd_check("ovr_rx_drained", 4'd5, 8'h00);

      // ---- framing error, glitch, recovery ----
      do_reset();
      set_div8();
      send_frame(8'h55, 1'b0);
      rd_check("ferr_status", 4'd1, 8'h48);
      rd_check("ferr_rx_count", 4'd5, 8'h00);
      bus_write(4'd4, 8'h0B);
      wait_cyc(2);
      rd_check("ferr_cleared", 4'd1, 8'h08);
      ui_in[7] = 1'b0; wait_cyc(2);
      ui_in[7] = 1'b1; wait_cyc(20);
      rd_check("glitch_status", 4'd1, 8'h08);
      rd_check("glitch_rx_count", 4'd5, 8'h00);
      send_frame(8'h96, 1'b1);
      wait_cyc(2);
      rd_check("recover_rx_count", 4'd5, 8'h01);
      bus_pop(4'd0, d);
      check("recover_rx_data", d, 8'h96);

      // ---- minimum divisor, TX overflow, flush ----
      do_reset();
      bus_write(4'd2, 8'h02);
      bus_write(4'd3, 8'h00);
      rd_check("div2_readback", 4'd2, 8'h02);
      bus_write(4'd0, 8'h55);
      wait_tx_fall();
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); n++;
         if (uo_out[0]) break;
      end
      check("div2_start_len", 8'(n), 8'd4);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); n++;
         if (!uo_out[0]) break;
      end
      check("div2_bit0_len", 8'(n), 8'd4);
      bus_write(4'd4, 8'h02);
      wait_cyc(50);
      for (int k = 0; k < 9; k++) bus_write(4'd0, 8'(k));
      rd_check("txovf_tx_count", 4'd6, 8'h08);
      rd_check("txovf_status", 4'd1, 8'h84);
      bus_write(4'd4, 8'h12);
      wait_cyc(2);
      rd_check("flush_tx_count", 4'd6, 8'h00);
      rd_check("flush_status", 4'd1, 8'h88);
      check("flush_line_idle", uo_out, 8'h01);

      // ---- reset in the middle of a frame ----
      do_reset();
      set_div8();
      bus_write(4'd4, 8'h02);
      bus_write(4'd0, 8'h00);
      bus_write(4'd0, 8'h00);
      bus_write(4'd4, 8'h03);
      wait_tx_fall();
      rd_check("midrst_tx_count_pre", 4'd6, 8'h01);
      wait_cyc(29);
      check("midrst_line_low", uo_out, 8'h00);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_uo_out", uo_out, 8'h01);
      rd_check("midrst_tx_count", 4'd6, 8'h00);
      rd_check("midrst_rx_count", 4'd5, 8'h00);
      rd_check("midrst_ctrl", 4'd4, 8'h03);
      rd_check("midrst_status", 4'd1, 8'h08);
      rst = 1'b0;
      wait_cyc(20);
      check("midrst_line_stays_idle", uo_out, 8'h01);
      check("midrst_dbg_idle", {4'b0, dbg_tx_state, dbg_rx_state}, 8'h00);

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/tqvp_uart_fifo.md
Name: tqvp_uart_fifo

Overview:
- Next-generation TinyQV UART peripheral: full-duplex 8N1 UART with programmable baud divisor and parametrised RX and TX FIFOs.
- Exposes a CPU register map over the standard 4-bit peripheral address bus.
- UART RX comes from ui_in[7]; UART TX drives uo_out[0].
- Adds status flags, sticky error flags, internal loopback and FIFO flush.

Parameters:
- FIFO_AW, 3, log2 of depth of each FIFO (depth = 2**FIFO_AW, 8 by default).
- DIV_W, 16, width of the baud divisor register.
- DIV_RESET, 556, reset divisor in clk cycles per bit (64 MHz / 115200).

Ports:
- clk  in  1  project clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ui_in  in  8  input PMOD; bit 7 = UART RX; bits 6:0 unused.
- uo_out  out  8  bit 0 = UART TX; bits 7:1 = 0.
- address  in  4  register select.
- data_write  in  1  one-cycle write strobe; data_in valid.
- data_read  in  1  one-cycle read strobe; pops RX FIFO when address = 0.
- data_in  in  8  write data.
- data_out  out  8  combinational read data for the current address.

Behaviour:
- Register map (unlisted addresses read 0x00 and ignore writes):
  - 0 DATA: write pushes TX FIFO; read returns RX head (0x00 if empty).
  - 1 STATUS RO: b0 rx_nonempty, b1 rx_full, b2 tx_full, b3 tx_empty, b4 tx_busy, b5 rx_overrun, b6 frame_err, b7 tx_overflow (b5–b7 sticky).
  - 2 DIV_LO; 3 DIV_HI (bits above DIV_W ignored).
  - 4 CTRL: b0 tx_en, b1 rx_en, b2 loopback, b3 clr_err (write-1, self-clearing), b4 flush (write-1, self-clearing; empties both FIFOs).
  - 5 RX_COUNT; 6 TX_COUNT (0..depth).
- Reset values:
  - tx line = 1; uo_out = 0x01.
  - FIFOs empty; sticky flags = 0.
  - DIV = DIV_RESET; CTRL = 0x03 (tx and rx enabled, no loopback).
  - data_out is the decode of reset state, so STATUS reads 0x08.
- Divisor: effective divisor is max(DIV, 4). A change takes effect at the next bit boundary and never truncates the current bit.
- TX FSM (IDLE, START, DATA, STOP), each bit lasting DIV cycles:
  - From IDLE, when tx_en and TX FIFO is non-empty: pop the head and drive start bit 0.
  - DATA sends 8 bits LSB first; STOP drives 1.
  - At the end of STOP, if the FIFO is non-empty, go straight to START with no idle gap. A frame is exactly 10*DIV cycles.
  - tx_busy = state != IDLE. Clearing tx_en lets the current frame finish.
- RX path:
  - Input passes a 2-flop synchronizer. In loopback, the RX input is the internal TX output and ui_in[7] is ignored.
  - FSM IDLE, START, DATA, STOP.
  - IDLE: a falling edge with rx_en set moves to START.
  - START samples at DIV/2. If the line reads 1, it is a false start: return to IDLE with nothing pushed.
  - DATA samples 8 bits, each DIV after the previous sample.
  - STOP samples after a further DIV. If the stop bit is 0, set frame_err, discard the byte, and wait for the line to return high before returning to IDLE.
  - If the stop bit is valid and the RX FIFO is full, set rx_overrun and discard the byte; otherwise push.
- FIFOs: circular buffers with FIFO_AW-bit pointers and an (FIFO_AW+1)-bit count.
  - Push and pop in the same cycle are both performed and the count is unchanged. This holds when full (one pop, one push) and is not an overrun.
  - Pop when empty is a no-op.
  - A DATA write when TX is full is dropped and sets tx_overflow.
  - Pointers wrap modulo depth.
- Clearing flags and flushing:
  - clr_err clears b5–b7 in the cycle after the write. An error event in that same cycle wins and the flag stays set.
  - flush takes priority over a simultaneous push or pop and does not abort frames in flight.
- Reset mid-frame: on the next edge the TX line returns to 1, both FSMs go to IDLE, and partial bytes are discarded.

Test Plan:
- Reset, DIV=8, write DATA=0xA5 → uo_out[0] = 0 (start), then bits 1,0,1,0,0,1,0,1, then 1; 80 cycles total; STATUS returns to 0x08.
- Loopback, DIV=8, write 0x3C, 0xC3 → back-to-back frames (160 cycles, no idle), RX_COUNT = 2, DATA reads (with data_read) return 0x3C then 0xC3, STATUS ends 0x08.
- Drive 9 valid frames on ui_in[7] with depth 8 and no reads → RX_COUNT = 8, STATUS b1 = 1 and b5 = 1; head byte is the first frame; write CTRL = 0x0B → b5 clears.
- Frame with stop bit 0 and data 0x55 → frame_err set, RX_COUNT unchanged; a 2-cycle low glitch on ui_in[7] → no push and no error.
- Write DIV = 2 → bit period measured as 4 cycles. Write 9 bytes with tx_en = 0 → TX_COUNT = 8 and tx_overflow = 1.
- Assert rst at cycle 30 of a frame → uo_out = 0x01 next cycle, counts 0, CTRL = 0x03.
